// File: rtl/nios2_dbg_pkg.sv
// Shared definitions for the Nios II JTAG debug command path (system-clock side).
// Holds the default widths, the instruction codes and the default-width command record.
package nios2_dbg_pkg;

  localparam int DEF_IR_WIDTH = 2;
  localparam int DEF_SR_WIDTH = 38;

  typedef enum logic [DEF_IR_WIDTH-1:0] {
    IR_OCIMEM    = 2'd0,
    IR_TRACEMEM  = 2'd1,
    IR_BREAK     = 2'd2,
    IR_TRACECTRL = 2'd3
  } ir_code_e;

  typedef struct packed {
    logic [DEF_IR_WIDTH-1:0] ir;
    logic [DEF_SR_WIDTH-1:0] data;
  } dbg_cmd_t;

endpackage

// File: rtl/nios2_dbg_sync_edge.sv
// Brings one TCK-domain strobe into clk through SYNC_STAGES flops and emits a
// single-cycle rising-edge pulse, suppressed until the strobe has been seen low.
module nios2_dbg_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   dly_q, dly_d;
  logic                   arm_q, arm_d;
  logic                   level;

  // NOTE: every variable gets a value at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    level  = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    vld_d  = {vld_q[SYNC_STAGES-2:0], 1'b1};
    dly_d  = level;
    // The reset zeros flushing out of the chain are not a real low sample, so
    // only arm once a genuinely sampled level has reached the last stage.
    arm_d  = arm_q | (vld_q[SYNC_STAGES-1] & ~level);
    edge_o = level & ~dly_q & arm_q;
  end

  // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      vld_q  <= '0;
      dly_q  <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      vld_q  <= vld_d;
      dly_q  <= dly_d;
      arm_q  <= arm_d;
    end
  end

endmodule

// File: rtl/nios2_dbg_cmd_sysclk_gen.sv
// System-clock side of the Nios II JTAG debug path: strobe sync, command capture,
// command buffer and per-instruction action strobes. Buffer depth selected by NIOS2_DBG_CMD_FIFO_EN.
module nios2_dbg_cmd_sysclk_gen
  import nios2_dbg_pkg::*;
#(
  parameter  int IR_WIDTH    = DEF_IR_WIDTH,
  parameter  int SR_WIDTH    = DEF_SR_WIDTH,
  parameter  int ACTION_BIT  = SR_WIDTH - 1,
  parameter  int CMD_DEPTH   = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int NUM_CH      = 2 ** IR_WIDTH,
  localparam int CNT_W       = $clog2(CMD_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vs_udr,
  input  logic                vs_uir,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [SR_WIDTH-1:0] sr,
  input  logic                cmd_ready,
  input  logic                ovf_clr,
  output logic                cmd_valid,
  output logic [SR_WIDTH-1:0] jdo,
  output logic [IR_WIDTH-1:0] cmd_ir,
  output logic [NUM_CH-1:0]   take_action,
  output logic [NUM_CH-1:0]   take_no_action,
  output logic                ir_update,
  output logic [CNT_W-1:0]    cmd_count,
  output logic                cmd_ovf
);

  typedef struct packed {
    logic [IR_WIDTH-1:0] ir;
    logic [SR_WIDTH-1:0] data;
  } cmd_t;

  logic             udr_edge, uir_edge;
  cmd_t             push_cmd, head;
  logic             valid, full, pop, push_ok, ovf_set;
  logic [CNT_W-1:0] count;
  logic             ovf_q, ovf_d;
  logic             ir_update_q, ir_update_d;

  nios2_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (vs_udr),
    .edge_o   (udr_edge)
  );

  nios2_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (vs_uir),
    .edge_o   (uir_edge)
  );

  // Handshake, overflow and action decode shared by both buffer variants.
  always_comb begin
    push_cmd.ir    = ir_in;
    push_cmd.data  = sr;
    pop            = valid & cmd_ready;
    push_ok        = udr_edge & (~full | pop);
    ovf_set        = udr_edge & full & ~pop;
    ovf_d          = ovf_set | (ovf_q & ~ovf_clr);
    ir_update_d    = uir_edge;
    take_action    = '0;
    take_no_action = '0;
    if (pop) begin
      if (head.data[ACTION_BIT]) take_action[head.ir]    = 1'b1;
      else                       take_no_action[head.ir] = 1'b1;
    end
  end

`ifdef NIOS2_DBG_CMD_FIFO_EN
  localparam int PTR_W = $clog2(CMD_DEPTH);

  cmd_t             mem_q [CMD_DEPTH];
  cmd_t             mem_d [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    valid = (count_q != '0);
    full  = (count_q == CNT_W'(CMD_DEPTH));
    head  = mem_q[rd_ptr_q];
    count = count_q;
  end

  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_cmd;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  // NOTE: the storage is reset too, because jdo/cmd_ir read it directly and must be 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  cmd_t hold_q, hold_d;
  logic hold_vld_q, hold_vld_d;

  always_comb begin
    valid = hold_vld_q;
    full  = hold_vld_q;
    head  = hold_q;
    count = CNT_W'(hold_vld_q);
  end

  // Data holds its last value once popped; only the valid bit drops.
  always_comb begin
    hold_d     = push_ok ? push_cmd : hold_q;
    hold_vld_d = push_ok | (hold_vld_q & ~pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q       <= 1'b0;
      ir_update_q <= 1'b0;
    end else begin
      ovf_q       <= ovf_d;
      ir_update_q <= ir_update_d;
    end
  end

  assign cmd_valid = valid;
  assign jdo       = head.data;
  assign cmd_ir    = head.ir;
  assign cmd_count = count;
  assign cmd_ovf   = ovf_q;
  assign ir_update = ir_update_q;

endmodule

// File: doc/nios2_dbg_cmd_sysclk_gen.md
# nios2_dbg_cmd_sysclk_gen

Parametrised system-clock side of the Nios II JTAG debug path. It synchronises the TCK-domain update-DR and update-IR strobes into `clk` and captures the debug shift register plus instruction code on each update-DR. The captured commands go into a small FIFO, and each popped command is decoded into per-instruction action/no-action strobes for the OCI. It generalises the fixed 2-bit-IR, 38-bit-SR, unbuffered sysclk decoder to configurable widths and synchroniser depth, and adds buffering, backpressure and overflow reporting.

## Interface
Parameters:
- IR_WIDTH, 2, instruction register width; NUM_CH = 2**IR_WIDTH channels
- SR_WIDTH, 38, debug shift register / jdo width
- ACTION_BIT, SR_WIDTH-1, jdo bit selecting action (1) vs no-action (0)
- CMD_DEPTH, 4, command FIFO depth; power of two, ≥2
- SYNC_STAGES, 2, synchroniser flops per strobe; ≥2

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- vs_udr  in  1  update-DR level from TCK domain, asynchronous
- vs_uir  in  1  update-IR level from TCK domain, asynchronous
- ir_in  in  IR_WIDTH  instruction code, quasi-static in TCK domain
- sr  in  SR_WIDTH  shift register contents, quasi-static after vs_udr rises
- cmd_ready  in  1  consumer accepts head command
- ovf_clr  in  1  clears cmd_ovf
- cmd_valid  out  1  FIFO non-empty
- jdo  out  SR_WIDTH  head command data
- cmd_ir  out  IR_WIDTH  head command instruction
- take_action  out  NUM_CH  one-hot pop strobe, jdo[ACTION_BIT]=1
- take_no_action  out  NUM_CH  one-hot pop strobe, jdo[ACTION_BIT]=0
- ir_update  out  1  one-cycle pulse per synchronised vs_uir rising edge
- cmd_count  out  $clog2(CMD_DEPTH+1)  occupancy
- cmd_ovf  out  1  sticky: a command was dropped

## Operation
- Each strobe passes through SYNC_STAGES flops, then a delay flop; edge = last stage & ~delay.
- Arm flag per strobe, cleared by reset. Set once the synchronised level is observed 0. Edges are suppressed while disarmed, so a strobe held high across reset release produces no command.
- udr edge: push {ir_in, sr}, both sampled in the edge cycle.
- Pop: cmd_valid & cmd_ready. take_action[cmd_ir] = pop & jdo[ACTION_BIT]; take_no_action[cmd_ir] = pop & ~jdo[ACTION_BIT]. All other bits are 0. Both are combinational from the handshake.
- Full, push, no pop: push dropped, cmd_ovf set, FIFO unchanged.
- Full, push, pop same cycle: both happen; count unchanged; no overflow.
- Empty: cmd_valid=0, take_* all 0; jdo/cmd_ir hold last value (do not care).
- ovf_clr together with a new overflow: set wins.
- Pointers are log2(CMD_DEPTH) bits and wrap naturally; cmd_count is separate, saturating-free because push is gated when full.

## Timing
- Reset values: cmd_valid 0, jdo 0, cmd_ir 0, take_* 0, ir_update 0, cmd_count 0, cmd_ovf 0; sync chains, delay flops, arm flags and pointers 0.
- vs_udr rising before clk edge 0: cmd_valid high after edge SYNC_STAGES+1, i.e. 3 edges for the default.
- Source requirement: sr and ir_in stable for SYNC_STAGES+3 clk cycles after vs_udr rises.
- ir_update: same SYNC_STAGES+1 edge latency as vs_udr, 1 cycle wide.
- Pop updates head and cmd_count at the next edge. Back-to-back pops are allowed every cycle.
- Reset mid-operation: all state cleared immediately (async); queued commands lost; no take_* strobe in the reset cycle.

## Configuration
- `NIOS2_DBG_CMD_FIFO_EN` defined: FIFO of CMD_DEPTH entries as above.
- Not defined: a single holding register replaces the FIFO. CMD_DEPTH is ignored and cmd_count is 0/1. A push while full and not popping is dropped and sets cmd_ovf. Handshake and latency are identical.

## Structure
- Package nios2_dbg_pkg holds:
  - IR code constants IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2, IR_TRACECTRL=3
  - default SR_WIDTH=38
  - a packed command struct {ir, data}
- Sub-module nios2_dbg_sync_edge: synchroniser, delay flop, arm flag and edge output, parametrised by SYNC_STAGES. Instantiated twice, for udr and uir.

## Test plan
- Reset release with vs_udr=1, then vs_udr held 20 cycles -> no push, cmd_valid=0; after vs_udr goes 0 then 1, exactly one command.
- ir_in=2, sr bit37=1, cmd_ready=1, one vs_udr pulse -> cmd_valid at edge 3; take_action=4'b0100 for one cycle; jdo equals sr.
- ir_in=0, sr bit37=0 -> take_no_action=4'b0001, take_action=0.
- cmd_ready=0, five udr pulses, CMD_DEPTH=4 -> cmd_count=4, cmd_ovf=1; pops return the first four in order; ovf_clr clears cmd_ovf.
- Full FIFO, push and pop in the same cycle -> count stays 4, cmd_ovf stays 0, new command at tail.
- Assert reset with 3 queued commands -> cmd_valid=0, cmd_count=0 immediately; one vs_uir pulse after reset -> single ir_update pulse.
